snn_sim_sequencer: RTL and testbench

Timestep sequencer for the SNN core. On a start command it resets the network neurons, then runs one pass per timestep until the programmed simulation time is reached. Each pass fetches that timestep's input spike batches from spike-pattern memory and enables each layer in order, waiting for the layer to report completion. It sits between the AXI configuration registers (CTRL_REG, SIM_TIME_REG) and the layer/neuron datapath, and it owns the spike-pattern memory read port while busy.

---
 rtl/snn_pkg.sv | 21 ++
 rtl/snn_sim_sequencer.sv | 157 +++++++++++++++
 tb/tb_snn_sim_sequencer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/snn_pkg.sv
// rtl/snn_pkg.sv - shared types and sizing for the SNN timestep sequencer
package snn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RST   = 3'd1,
    ST_FETCH = 3'd2,
    ST_LAYER = 3'd3,
    ST_STEP  = 3'd4,
    ST_DONE  = 3'd5
  } snn_seq_state_t;

  localparam int BATCH_AW     = 1;
  localparam int NB           = 1 << BATCH_AW;
  localparam int SPIKE_WORD_W = 32 * NB;

  function automatic int batch_count(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/snn_sim_sequencer.sv
// rtl/snn_sim_sequencer.sv - timestep sequencer: neuron reset, spike fetch, ordered layer enables
module snn_sim_sequencer
  import snn_pkg::*;
#(
  parameter int NUM_INPUTS                     = 9,
  parameter int NUM_LAYERS                     = 2,
  parameter int MAX_TIMESTEPS_BITS             = 4,
  parameter int SPIKE_PATTERN_BATCH_ADDR_WIDTH = BATCH_AW
) (
  input  logic                                                   S_AXI_ACLK,
  input  logic                                                   S_AXI_ARESETN,
  input  logic                                                   start,
  input  logic                                                   abort,
  input  logic [MAX_TIMESTEPS_BITS:0]                            sim_time,
  output logic                                                   spk_rd_en,
  output logic [MAX_TIMESTEPS_BITS+SPIKE_PATTERN_BATCH_ADDR_WIDTH-1:0] spk_rd_addr,
  input  logic [31:0]                                            spk_rd_data,
  output logic [NUM_INPUTS-1:0]                                  input_spikes,
  output logic                                                   neuron_rst,
  output logic [NUM_LAYERS-1:0]                                  layer_en,
  input  logic [NUM_LAYERS-1:0]                                  layer_done,
  output logic [MAX_TIMESTEPS_BITS:0]                            timestep,
  output logic                                                   busy,
  output logic                                                   done
);

  localparam int TW         = MAX_TIMESTEPS_BITS + 1;
  localparam int AW         = SPIKE_PATTERN_BATCH_ADDR_WIDTH;
  localparam int BW         = AW + 1;
  localparam int LW         = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam int RAW        = MAX_TIMESTEPS_BITS + AW;
  localparam int SEQ_NB     = batch_count(AW);
  localparam int SEQ_WORD_W = 32 * SEQ_NB;

  localparam logic [TW-1:0] TS_MAX = {1'b1, {MAX_TIMESTEPS_BITS{1'b0}}};
  localparam logic [BW-1:0] NB_B   = BW'(SEQ_NB);
  localparam logic [LW-1:0] LAST_L = LW'(NUM_LAYERS - 1);

  if (NUM_INPUTS > SEQ_WORD_W) begin : g_bad_num_inputs
    $error("NUM_INPUTS exceeds the spike word width");
  end

  snn_seq_state_t    state_q, state_d;
  logic [TW-1:0]     ts_q, ts_d;
  logic [TW-1:0]     eff_q, eff_d;
  logic [BW-1:0]     batch_q, batch_d;
  logic [LW-1:0]     layer_q, layer_d;

  logic              rd_en_q, rd_en_d;
  logic [RAW-1:0]    rd_addr_q, rd_addr_d;
  logic [NUM_LAYERS-1:0] layer_en_q, layer_en_d;
  logic              neuron_rst_q, busy_q, done_q;

  logic              cap_q;
  logic [AW-1:0]     cap_batch_q;
  logic [SEQ_WORD_W-1:0] word_q;

  always_comb begin
    state_d = state_q;
    ts_d    = ts_q;
    eff_d   = eff_q;
    batch_d = batch_q;
    layer_d = layer_q;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d = ST_RST;
          ts_d    = '0;
          eff_d   = (sim_time > TS_MAX) ? TS_MAX : sim_time;
        end
      end
      ST_RST: begin
        batch_d = '0;
        state_d = (eff_q == '0) ? ST_DONE : ST_FETCH;
      end
      ST_FETCH: begin
        // batch_q == NB is the drain cycle waiting for the last read's data
        if (batch_q == NB_B) begin
          state_d = ST_LAYER;
          layer_d = '0;
        end else begin
          batch_d = batch_q + BW'(1);
        end
      end
      ST_LAYER: begin
        if (|(layer_done & layer_en_q)) begin
          if (layer_q == LAST_L) state_d = ST_STEP;
          else                   layer_d = layer_q + LW'(1);
        end
      end
      ST_STEP: begin
        ts_d    = ts_q + TW'(1);
        batch_d = '0;
        state_d = (ts_d == eff_q) ? ST_DONE : ST_FETCH;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (abort) state_d = ST_IDLE;

    rd_en_d    = (state_d == ST_FETCH) && (batch_d < NB_B);
    rd_addr_d  = rd_en_d ? {ts_d[MAX_TIMESTEPS_BITS-1:0], batch_d[AW-1:0]} : '0;
    layer_en_d = (state_d == ST_LAYER) ? (NUM_LAYERS'(1) << layer_d) : '0;
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q      <= ST_IDLE;
      ts_q         <= '0;
      eff_q        <= '0;
      batch_q      <= '0;
      layer_q      <= '0;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      layer_en_q   <= '0;
      neuron_rst_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cap_q        <= 1'b0;
      cap_batch_q  <= '0;
      word_q       <= '0;
    end else begin
      state_q      <= state_d;
      ts_q         <= ts_d;
      eff_q        <= eff_d;
      batch_q      <= batch_d;
      layer_q      <= layer_d;
      rd_en_q      <= rd_en_d;
      rd_addr_q    <= rd_addr_d;
      layer_en_q   <= layer_en_d;
      neuron_rst_q <= (state_d == ST_RST);
      busy_q       <= (state_d != ST_IDLE);
      done_q       <= (state_d == ST_DONE);
      // read data arrives one cycle after the strobe, tagged by the batch it was issued for
      cap_q        <= rd_en_q;
      cap_batch_q  <= rd_addr_q[AW-1:0];
      for (int b = 0; b < SEQ_NB; b++) begin
        if (cap_q && cap_batch_q == AW'(b)) word_q[b*32 +: 32] <= spk_rd_data;
      end
    end
  end

  logic unused_word;
  assign unused_word = ^word_q;

  assign spk_rd_en    = rd_en_q;
  assign spk_rd_addr  = rd_addr_q;
  assign input_spikes = word_q[NUM_INPUTS-1:0];
  assign neuron_rst   = neuron_rst_q;
  assign layer_en     = layer_en_q;
  assign timestep     = ts_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_snn_sim_sequencer.sv
// tb/tb_snn_sim_sequencer.sv - self-checking bench for snn_sim_sequencer
module tb_snn_sim_sequencer;

  localparam int NI = 9;
  localparam int NL = 2;
  localparam int MB = 4;
  localparam int NBT = 2;
  localparam int MAXT = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, abort;
  logic [MB:0]   sim_time;
  logic          spk_rd_en;
  logic [MB:0]   spk_rd_addr;
  logic [31:0]   spk_rd_data;
  logic [NI-1:0] input_spikes;
  logic          neuron_rst;
  logic [NL-1:0] layer_en;
  logic [NL-1:0] layer_done;
  logic [MB:0]   timestep;
  logic          busy, done;

  snn_sim_sequencer #(
    .NUM_INPUTS(NI), .NUM_LAYERS(NL), .MAX_TIMESTEPS_BITS(MB), .SPIKE_PATTERN_BATCH_ADDR_WIDTH(1)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .start(start), .abort(abort), .sim_time(sim_time),
    .spk_rd_en(spk_rd_en), .spk_rd_addr(spk_rd_addr), .spk_rd_data(spk_rd_data),
    .input_spikes(input_spikes), .neuron_rst(neuron_rst), .layer_en(layer_en),
    .layer_done(layer_done), .timestep(timestep), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // spike-pattern memory: data one cycle after the strobe, noise otherwise
  logic [31:0] mem [32];
  always @(posedge clk) spk_rd_data <= spk_rd_en ? mem[spk_rd_addr] : $urandom;

  // layer responder: done 'lat' cycles after enable, optional noise on idle layers
  int            lat = 3;
  logic          noise_en = 1'b0;
  int            cnt [NL];
  logic [NL-1:0] noise_q;
  always @(posedge clk) begin
    for (int l = 0; l < NL; l++) cnt[l] <= layer_en[l] ? cnt[l] + 1 : 0;
    noise_q <= NL'($urandom);
  end
  always_comb begin
    layer_done = '0;
    for (int l = 0; l < NL; l++)
      layer_done[l] = (layer_en[l] && cnt[l] >= lat) || (noise_en && noise_q[l] && !layer_en[l]);
  end

  // monitor: cycle 0 is the start cycle
  logic          mon_on = 1'b0;
  int            cyc, rst_cnt, rst_cyc, done_cnt, done_cyc, first_busy, last_busy, spk_bad, l0_rises;
  logic [NL-1:0] prev_en;
  logic [NI-1:0] first_spk;
  int            rd_log [$];
  int            rise_log [$];
  always @(negedge clk) begin
    if (!mon_on) begin
      cyc <= -1; rst_cnt <= 0; rst_cyc <= -1; done_cnt <= 0; done_cyc <= -1;
      first_busy <= -1; last_busy <= -1; spk_bad <= 0; l0_rises <= 0;
      prev_en <= '0; first_spk <= '0;
      rd_log.delete(); rise_log.delete();
    end else begin
      cyc <= cyc + 1;
      if (spk_rd_en) rd_log.push_back(int'(spk_rd_addr));
      if (neuron_rst) begin rst_cnt <= rst_cnt + 1; rst_cyc <= cyc + 1; end
      if (done) begin done_cnt <= done_cnt + 1; done_cyc <= cyc + 1; end
      if (busy) begin
        last_busy <= cyc + 1;
        if (first_busy < 0) first_busy <= cyc + 1;
      end
      for (int l = 0; l < NL; l++) begin
        if (layer_en[l] && !prev_en[l]) begin
          rise_log.push_back(l);
          if (l == 0) begin
            if (l0_rises == 0) first_spk <= input_spikes;
            if (l0_rises < MAXT && input_spikes !== mem[NBT*l0_rises][NI-1:0]) spk_bad <= spk_bad + 1;
            l0_rises <= l0_rises + 1;
          end
        end
      end
      prev_en <= layer_en;
    end
  end

  function automatic int eff_of(input int s);
    return (s > MAXT) ? MAXT : s;
  endfunction

  function automatic int done_cycle_of(input int s, input int l);
    return 2 + eff_of(s) * ((NBT + 1) + NL * (l + 1) + 1);
  endfunction

  task automatic randomize_mem();
    for (int a = 0; a < 32; a++) mem[a] = $urandom;
  endtask

  task automatic begin_run(input int s, input int l, input bit noise);
    lat = l;
    noise_en = noise;
    mon_on = 1'b0;
    @(posedge clk); #1;
    sim_time = 5'(s);
    start = 1'b1;
    mon_on = 1'b1;
  endtask

  task automatic run(input int s, input int l, input int extra, input bit noise,
                     input int exp_ts, input int exp_reads, input int exp_done);
    int bad;
    int k;
    begin_run(s, l, noise);
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      start = (i + 1 == extra);
      sim_time = 5'($urandom);
      if (done_cnt != 0) break;
    end
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("done_count", done_cnt, 1);
    check("done_cycle", done_cyc, exp_done);
    check("rst_count", rst_cnt, 1);
    check("rst_cycle", rst_cyc, 1);
    check("busy_first", first_busy, 1);
    check("busy_last", last_busy, exp_done);
    check("rd_count", rd_log.size(), exp_reads);
    bad = 0; k = 0;
    for (int t = 0; t < exp_ts; t++)
      for (int b = 0; b < NBT; b++) begin
        if (k >= rd_log.size() || rd_log[k] != t * NBT + b) bad++;
        k++;
      end
    check("rd_order", bad, 0);
    check("layer_rises", rise_log.size(), NL * exp_ts);
    bad = 0;
    for (int r = 0; r < rise_log.size(); r++) if (rise_log[r] != r % NL) bad++;
    check("layer_order", bad, 0);
    check("input_spikes", spk_bad, 0);
    check("timestep_final", timestep, exp_ts);
  endtask

  typedef struct {
    int sim; int lat; int extra; int exp_ts; int exp_reads; int exp_done;
  } vec_t;

  vec_t vecs [7];
  int   found;
  int   s_r, l_r;

  initial begin
    vecs[0] = '{16, 3, 0,  16, 32, 194};
    vecs[1] = '{ 0, 3, 0,   0,  0,   2};
    vecs[2] = '{20, 3, 0,  16, 32, 194};
    vecs[3] = '{ 1, 0, 0,   1,  2,   8};
    vecs[4] = '{ 3, 1, 10,  3,  6,  26};
    vecs[5] = '{31, 4, 0,  16, 32, 226};
    vecs[6] = '{17, 2, 0,  16, 32, 162};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; sim_time = '0;
    randomize_mem();
    mem[0] = 32'h0FA50FA5;
    mem[1] = 32'hF05AF021;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {spk_rd_en, spk_rd_addr, input_spikes, neuron_rst, layer_en, timestep, busy, done}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      if (i != 0) randomize_mem();
      run(vecs[i].sim, vecs[i].lat, vecs[i].extra, 1'b0, vecs[i].exp_ts, vecs[i].exp_reads, vecs[i].exp_done);
      if (i == 0) check("first_input_spikes", first_spk, 9'h1A5);
    end

    for (int r = 0; r < 8; r++) begin
      s_r = $urandom_range(0, 31);
      l_r = $urandom_range(0, 4);
      randomize_mem();
      run(s_r, l_r, 0, 1'b1, eff_of(s_r), NBT * eff_of(s_r), done_cycle_of(s_r, l_r));
    end

    // abort during layer 1 of timestep 5
    begin_run(16, 3, 1'b0);
    found = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (layer_en[1] && timestep == 5) begin found = 1; break; end
    end
    check("abort_reached", found, 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_outputs", {busy, layer_en, spk_rd_en, done}, 0);
    repeat (5) begin @(posedge clk); #1; end
    check("abort_no_done", done_cnt, 0);
    run(4, 3, 0, 1'b0, 4, 8, done_cycle_of(4, 3));

    // start and abort together while idle
    begin_run(5, 3, 1'b0);
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check("start_abort_idle", {busy, neuron_rst}, 0);
    repeat (4) begin @(posedge clk); #1; end
    check("start_abort_reads", rd_log.size() + done_cnt + rst_cnt, 0);

    // asynchronous reset in the middle of a fetch
    begin_run(8, 3, 1'b0);
    found = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (spk_rd_en && timestep == 2) begin found = 1; break; end
    end
    check("fetch_reached", found, 1);
    rst_n = 1'b0;
    #1;
    check("async_reset", {spk_rd_en, spk_rd_addr, input_spikes, neuron_rst, layer_en, timestep, busy, done}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run(2, 1, 0, 1'b0, 2, 4, done_cycle_of(2, 1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
